capture_sequencer: RTL

- Run-control state machine for the DSO acquisition path. It sequences adc_driver arm → trigger → buffer fill → host readout → re-arm.
- Supports STOP, SINGLE, NORMAL and AUTO run modes, a programmable holdoff and an auto-trigger timeout.
- Sits between the SPI register file (host side) and adc_driver (driver side).

---
 rtl/dso_seq_pkg.sv | 20 ++
 rtl/seq_timer.sv | 27 ++
 rtl/capture_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dso_seq_pkg.sv
// Shared run-mode codes and state encodings for the capture run-control path.
package dso_seq_pkg;

  localparam logic [1:0] MODE_STOP   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_NORMAL = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'd3;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HOLDOFF   = 3'd1;
  localparam logic [2:0] S_ARM       = 3'd2;
  localparam logic [2:0] S_WAIT_TRIG = 3'd3;
  localparam logic [2:0] S_FILL      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  function automatic logic mode_rearms(input logic [1:0] m);
    return (m == MODE_NORMAL) || (m == MODE_AUTO);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that stops at zero; zero_o flags the terminal count.
module seq_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// DSO acquisition run-control: arm -> trigger -> fill -> readout -> re-arm.
// Define SEQ_FRAME_COUNTER_EN to build the frame_count counter (tied to 0 otherwise).
module capture_sequencer #(
  parameter int unsigned HO_W = 16,
  parameter int unsigned TO_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      run_mode,
  input  logic            start,
  input  logic            stop,
  input  logic [HO_W-1:0] holdoff,
  input  logic [TO_W-1:0] auto_timeout,
  input  logic            host_ready,
  input  logic            host_done,
  output logic            drv_trigger_req,
  output logic            drv_force_trig,
  output logic            drv_ready,
  input  logic            drv_waiting,
  input  logic            drv_triggered,
  input  logic            drv_valid,
  output logic            frame_ready,
  output logic            auto_fired,
  output logic            busy,
  output logic [2:0]      state_o,
  output logic [15:0]     frame_count
);

  import dso_seq_pkg::*;

  logic [2:0] state_q, state_d;
  logic [1:0] mode_q;
  logic       to_en_q;
  logic       trig_req_q, force_q, drv_ready_q, frame_ready_q, auto_fired_q, busy_q;
  logic       ho_zero, to_zero, ho_load, to_load, mode_load, fire;

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (start && (run_mode != MODE_STOP)) state_d = S_HOLDOFF;
        S_HOLDOFF:   if (ho_zero) state_d = S_ARM;
        S_ARM:       if (drv_waiting) state_d = S_WAIT_TRIG;
        S_WAIT_TRIG: if (drv_triggered) state_d = S_FILL;
        S_FILL:      if (drv_valid) state_d = S_DONE;
        S_DONE:      if (host_done) state_d = mode_rearms(run_mode) ? S_HOLDOFF : S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  assign ho_load   = (state_d == S_HOLDOFF)   && (state_q != S_HOLDOFF);
  assign to_load   = (state_d == S_WAIT_TRIG) && (state_q != S_WAIT_TRIG);
  assign mode_load = !stop && (((state_q == S_IDLE) && start) || ((state_q == S_DONE) && host_done));

  // Timer is loaded with timeout-1 so the force pulse lands exactly auto_timeout clks after entry.
  assign fire = !stop && (state_q == S_WAIT_TRIG) && to_en_q && to_zero
              && !auto_fired_q && !drv_triggered;

  seq_timer #(.W(HO_W)) u_holdoff_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ho_load),
    .load_val_i (holdoff),
    .en_i       (state_q == S_HOLDOFF),
    .zero_o     (ho_zero)
  );

  seq_timer #(.W(TO_W)) u_timeout_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load),
    .load_val_i (auto_timeout - TO_W'(1)),
    .en_i       (state_q == S_WAIT_TRIG),
    .zero_o     (to_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_STOP;
      to_en_q       <= 1'b0;
      trig_req_q    <= 1'b0;
      force_q       <= 1'b0;
      drv_ready_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      auto_fired_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != S_IDLE);
      trig_req_q    <= (state_d == S_ARM);
      force_q       <= fire;
      drv_ready_q   <= (state_d == S_DONE) && host_ready;
      frame_ready_q <= (state_d == S_DONE);
      if (mode_load) mode_q <= run_mode;
      if (to_load) to_en_q <= (mode_q == MODE_AUTO) && (auto_timeout != '0);
      if (stop) begin
        auto_fired_q <= 1'b0;
      end else if (fire) begin
        auto_fired_q <= 1'b1;
      end else if ((state_q == S_DONE) && host_done) begin
        auto_fired_q <= 1'b0;
      end
    end
  end

`ifdef SEQ_FRAME_COUNTER_EN
  logic [15:0] frame_count_q;
  logic        frame_done;

  assign frame_done = (state_q == S_FILL) && (state_d == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= '0;
    end else if (frame_done) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

  assign state_o         = state_q;
  assign busy            = busy_q;
  assign drv_trigger_req = trig_req_q;
  assign drv_force_trig  = force_q;
  assign drv_ready       = drv_ready_q;
  assign frame_ready     = frame_ready_q;
  assign auto_fired      = auto_fired_q;

endmodule
